// File: rtl/ecl_trig_receiver.sv
// Quad ECL trigger receiver: synchronise, edge-detect, stretch and count A..D, and watch the D true/complement pair.
// Optional macro TUBII_TRIG_COINC_EN adds a COINC output and a coincidence counter read as channel 4.
module ecl_trig_receiver #(
  parameter int CNT_W        = 16,
  parameter int STRETCH      = 4,
  parameter int FAULT_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       TRIG_IN,
  input  logic             TRIG_D_N,
  input  logic             CLEAR,
  input  logic             RD_REQ,
`ifdef TUBII_TRIG_COINC_EN
  input  logic [2:0]       RD_SEL,
`else
  input  logic [1:0]       RD_SEL,
`endif
  output logic [3:0]       TRIG_OUT,
  output logic [CNT_W-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             DIFF_FAULT
`ifdef TUBII_TRIG_COINC_EN
  ,
  output logic             COINC
`endif
);

  localparam logic [7:0]       STRETCH_LD = 8'(STRETCH - 1);
  localparam logic [3:0]       FAULT_LIM  = 4'(FAULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [3:0]       sync1_q, sync2_q, prev_q;
  logic             dn1_q, dn2_q;
  logic [3:0]       edge_w;
  logic [7:0]       timer_q [4];
  logic [7:0]       timer_d [4];
  logic [3:0]       trig_q, trig_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       mism_q, mism_d;
  logic             fault_q, fault_d;
  logic             rd_req_q;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] rd_mux;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q;
`ifdef TUBII_TRIG_COINC_EN
  logic             coinc_q, coinc_d;
  logic [CNT_W-1:0] coinc_cnt_q, coinc_cnt_d;
`endif

  assign edge_w = sync2_q & ~prev_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      trig_d[i]  = 1'b0;
      timer_d[i] = timer_q[i];
      cnt_d[i]   = cnt_q[i];
      // A new edge always reloads, so overlapping pulses merge into one longer pulse.
      if (edge_w[i]) begin
        timer_d[i] = STRETCH_LD;
        trig_d[i]  = 1'b1;
      end else if (timer_q[i] != 8'd0) begin
        timer_d[i] = timer_q[i] - 8'd1;
        trig_d[i]  = 1'b1;
      end
      if (CLEAR) begin
        cnt_d[i] = '0;
      end else if (edge_w[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mism_d  = mism_q;
    fault_d = fault_q;
    if (CLEAR) begin
      mism_d  = 4'd0;
      fault_d = 1'b0;
    end else begin
      if (sync2_q[3] == dn2_q) begin
        mism_d = (mism_q == FAULT_LIM) ? mism_q : mism_q + 4'd1;
      end else begin
        mism_d = 4'd0;
      end
      fault_d = fault_q | (mism_d == FAULT_LIM);
    end
  end

`ifdef TUBII_TRIG_COINC_EN
  always_comb begin
    coinc_d     = ($countones(edge_w) > 1);
    coinc_cnt_d = coinc_cnt_q;
    if (CLEAR) begin
      coinc_cnt_d = '0;
    end else if (coinc_d && (coinc_cnt_q != CNT_MAX)) begin
      coinc_cnt_d = coinc_cnt_q + CNT_W'(1);
    end
  end
`endif

  // Counter values are taken before this edge's increments; the result appears one edge later.
  always_comb begin
    rd_mux = '0;
`ifdef TUBII_TRIG_COINC_EN
    case (RD_SEL)
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = cnt_q[RD_SEL[1:0]];
      3'd4:                   rd_mux = coinc_cnt_q;
      default:                rd_mux = '0;
    endcase
`else
    rd_mux = cnt_q[RD_SEL];
`endif
    cap_d     = RD_REQ   ? rd_mux : cap_q;
    rd_data_d = rd_req_q ? cap_q  : rd_data_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q    <= 4'd0;
      sync2_q    <= 4'd0;
      prev_q     <= 4'd0;
      dn1_q      <= 1'b0;
      dn2_q      <= 1'b0;
      trig_q     <= 4'd0;
      mism_q     <= 4'd0;
      fault_q    <= 1'b0;
      rd_req_q   <= 1'b0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        timer_q[i] <= 8'd0;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q    <= TRIG_IN;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      dn1_q      <= TRIG_D_N;
      dn2_q      <= dn1_q;
      trig_q     <= trig_d;
      mism_q     <= mism_d;
      fault_q    <= fault_d;
      rd_req_q   <= RD_REQ;
      cap_q      <= cap_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_req_q;
      for (int i = 0; i < 4; i++) begin
        timer_q[i] <= timer_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef TUBII_TRIG_COINC_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      coinc_q     <= 1'b0;
      coinc_cnt_q <= '0;
    end else begin
      coinc_q     <= coinc_d;
      coinc_cnt_q <= coinc_cnt_d;
    end
  end

  assign COINC = coinc_q;
`endif

  assign TRIG_OUT   = trig_q;
  assign RD_DATA    = rd_data_q;
  assign RD_VALID   = rd_valid_q;
  assign DIFF_FAULT = fault_q;

endmodule
